// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequencer for the combinational AES-128 round-key
// generator. Accepts a cipher key on a valid/ready handshake, steps the
// generator one round per cycle and stores every round key in a key file
// with a registered read port.
//
// Handshake: a key is accepted on a rising edge where i_key_vld and
// o_key_rdy are both high; the source holds i_key stable until then.
//
// Optional feature macro: AES_KEYSCHED_ZEROIZE_EN adds the i_zeroize port,
// which wipes the key file, working key and read data and aborts expansion.
module aes_key_sched_ctrl #(
   parameter int NR    = 10,
   parameter int KEY_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_key_vld,
   input  logic [KEY_W-1:0] i_key,
   output logic             o_key_rdy,
   output logic [KEY_W-1:0] o_kg_pre_key,
   output logic             o_kg_en,
   output logic [3:0]       o_kg_round,
   input  logic [KEY_W-1:0] i_kg_next_key,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_keys_vld,
   input  logic             i_rd_en,
   input  logic [3:0]       i_rd_idx,
   output logic [KEY_W-1:0] o_rd_key,
   output logic             o_rd_vld,
`ifdef AES_KEYSCHED_ZEROIZE_EN
   input  logic             i_zeroize,
`endif
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       rnd;
   logic [KEY_W-1:0] work;
   logic [KEY_W-1:0] key_file [0:NR];
   logic [KEY_W-1:0] rd_mux;
   logic             zeroize;
   logic             key_hs;

`ifdef AES_KEYSCHED_ZEROIZE_EN
   assign zeroize = i_zeroize;
`else
   assign zeroize = 1'b0;
`endif

   // zeroize discards a key offered in the same cycle
   assign key_hs    = i_key_vld & o_key_rdy & ~zeroize;
   assign dbg_state = state;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; zeroize overrides everything
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (key_hs) state_nxt = ST_EXPAND;
         ST_EXPAND: if (rnd == 4'(NR)) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (zeroize) state_nxt = ST_IDLE;
   end

   // FSM outputs; generator is disabled (pass-through) outside EXPAND
   always_comb begin
      o_key_rdy    = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      o_kg_en      = 1'b0;
      o_kg_round   = 4'd0;
      o_kg_pre_key = '0;
      case (state)
         ST_IDLE: begin
            o_key_rdy = 1'b1;
         end
         ST_EXPAND: begin
            o_busy       = 1'b1;
            o_kg_en      = 1'b1;
            o_kg_round   = rnd;
            o_kg_pre_key = work;
         end
         ST_DONE: begin
            o_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // round counter, working key and key file writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd        <= 4'd0;
         work       <= '0;
         o_keys_vld <= 1'b0;
         for (int i = 0; i <= NR; i++) key_file[i] <= '0;
      end else if (zeroize) begin
         rnd        <= 4'd0;
         work       <= '0;
         o_keys_vld <= 1'b0;
         for (int i = 0; i <= NR; i++) key_file[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_hs) begin
                  key_file[0] <= i_key;
                  work        <= i_key;
                  rnd         <= 4'd1;
                  o_keys_vld  <= 1'b0;
               end
            end
            ST_EXPAND: begin
               for (int i = 1; i <= NR; i++) begin
                  if (rnd == 4'(i)) key_file[i] <= i_kg_next_key;
               end
               work <= i_kg_next_key;
               rnd  <= rnd + 4'd1;
            end
            ST_DONE: begin
               o_keys_vld <= 1'b1;
               rnd        <= 4'd0;
            end
            default: begin
               rnd <= 4'd0;
            end
         endcase
      end
   end

   // read mux; indices beyond the last round return zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i <= NR; i++) begin
         if (i_rd_idx == 4'(i)) rd_mux = key_file[i];
      end
   end

   // registered read port; sees the pre-write slot contents of this cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rd_key <= '0;
         o_rd_vld <= 1'b0;
      end else begin
         o_rd_vld <= i_rd_en;
         if (zeroize) begin
            o_rd_key <= '0;
         end else if (i_rd_en) begin
            o_rd_key <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed testbench for aes_key_sched_ctrl with a behavioural AES-128
// round-key generator closing the loop around the controller.
module tb_aes_key_sched_ctrl;

   localparam int NR = 10;
   localparam logic [127:0] FIPS_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] FIPS_K1   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
   localparam logic [127:0] FIPS_K10  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] ZERO_K1   = 128'h62636363_62636363_62636363_62636363;
   localparam logic [127:0] ZERO_K10  = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
   localparam logic [127:0] OTHER_KEY = 128'h00112233_44556677_8899aabb_ccddeeff;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_key_vld;
   logic [127:0] i_key;
   logic         o_key_rdy;
   logic [127:0] o_kg_pre_key;
   logic         o_kg_en;
   logic [3:0]   o_kg_round;
   logic [127:0] i_kg_next_key;
   logic         o_busy;
   logic         o_done;
   logic         o_keys_vld;
   logic         i_rd_en;
   logic [3:0]   i_rd_idx;
   logic [127:0] o_rd_key;
   logic         o_rd_vld;
   logic         i_zeroize;
   logic [1:0]   dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [127:0] exp_keys [0:15];

   always #5 clk = ~clk;

   aes_key_sched_ctrl #(.NR(NR), .KEY_W(128)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_key_vld     (i_key_vld),
      .i_key         (i_key),
      .o_key_rdy     (o_key_rdy),
      .o_kg_pre_key  (o_kg_pre_key),
      .o_kg_en       (o_kg_en),
      .o_kg_round    (o_kg_round),
      .i_kg_next_key (i_kg_next_key),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_keys_vld    (o_keys_vld),
      .i_rd_en       (i_rd_en),
      .i_rd_idx      (i_rd_idx),
      .o_rd_key      (o_rd_key),
      .o_rd_vld      (o_rd_vld),
`ifdef AES_KEYSCHED_ZEROIZE_EN
      .i_zeroize     (i_zeroize),
`endif
      .dbg_state     (dbg_state)
   );

   // ---------------- AES-128 key generator model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      inv = 8'h00;
      if (b != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
         4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
         4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
         4'd10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] kg_model(input logic [127:0] pre, input logic [3:0] r);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = pre[127:96]; w1 = pre[95:64]; w2 = pre[63:32]; w3 = pre[31:0];
      t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      t = t ^ {rcon(r), 24'h000000};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   always_comb begin
      i_kg_next_key = o_kg_en ? kg_model(o_kg_pre_key, o_kg_round) : o_kg_pre_key;
   end

   task automatic build_exp(input logic [127:0] key);
      for (int i = 0; i < 16; i++) exp_keys[i] = '0;
      exp_keys[0] = key;
      for (int i = 1; i <= NR; i++) exp_keys[i] = kg_model(exp_keys[i-1], 4'(i));
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_rdy();
      int n;
      n = 0;
      while (!o_key_rdy && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!o_key_rdy) begin
         checks++; failures++;
         $display("FAIL wait_rdy: o_key_rdy=%0b after %0d cycles, required 1", o_key_rdy, n);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!o_done && n < 40) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (!o_done) begin
         failures++;
         $display("FAIL wait_done: o_done=%0b after %0d cycles, required 1", o_done, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_key(input logic [127:0] key);
      wait_rdy();
      i_key = key; i_key_vld = 1'b1;
      @(posedge clk); #1;
      i_key_vld = 1'b0;
   endtask

   task automatic read_slot(input logic [3:0] idx, input logic [127:0] exp, input string name);
      i_rd_en = 1'b1; i_rd_idx = idx;
      @(posedge clk); #1;
      i_rd_en = 1'b0;
      checks++;
      if (o_rd_vld !== 1'b1) begin
         failures++;
         $display("FAIL %s rd_vld: got %0b required 1", name, o_rd_vld);
      end
      checks++;
      if (o_rd_key !== exp) begin
         failures++;
         $display("FAIL %s idx=%0d: got %h required %h", name, idx, o_rd_key, exp);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({o_busy, o_done, o_keys_vld, o_rd_vld, o_kg_en} !== 5'b0 ||
          o_kg_round !== 4'd0 || o_kg_pre_key !== '0 || o_rd_key !== '0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%0b done=%0b kv=%0b rv=%0b en=%0b rnd=%0d pre=%h rd=%h required all 0",
                  o_busy, o_done, o_keys_vld, o_rd_vld, o_kg_en, o_kg_round, o_kg_pre_key, o_rd_key);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o_key_rdy !== 1'b1) begin
         failures++;
         $display("FAIL reset_key_rdy: got %0b required 1", o_key_rdy);
      end
      read_slot(4'd0, 128'h0, "reset_slot0");
   endtask

   task automatic test_fips();
      int cyc;
      bit seen;
      build_exp(FIPS_KEY);
      wait_rdy();
      i_key = FIPS_KEY; i_key_vld = 1'b1;
      cyc = 0; seen = 1'b0;
      while (cyc < 30 && !seen) begin
         @(posedge clk); #1;
         i_key_vld = 1'b0;
         cyc++;
         if (cyc == 1) begin
            checks++;
            if (o_busy !== 1'b1 || o_key_rdy !== 1'b0 || o_kg_en !== 1'b1 ||
                o_kg_round !== 4'd1 || o_kg_pre_key !== FIPS_KEY) begin
               failures++;
               $display("FAIL fips_first_expand: busy=%0b rdy=%0b en=%0b rnd=%0d pre=%h required 1 0 1 1 %h",
                        o_busy, o_key_rdy, o_kg_en, o_kg_round, o_kg_pre_key, FIPS_KEY);
            end
         end
         if (o_done) seen = 1'b1;
      end
      checks++;
      if (!seen || cyc != NR + 1) begin
         failures++;
         $display("FAIL fips_done_latency: got cycle %0d (seen=%0b) required %0d", cyc, seen, NR + 1);
      end
      checks++;
      if (o_kg_en !== 1'b0 || o_kg_round !== 4'd0 || o_key_rdy !== 1'b0) begin
         failures++;
         $display("FAIL fips_done_outputs: en=%0b rnd=%0d rdy=%0b required 0 0 0", o_kg_en, o_kg_round, o_key_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (o_key_rdy !== 1'b1 || o_keys_vld !== 1'b1 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL fips_after_done: rdy=%0b keys_vld=%0b done=%0b required 1 1 0", o_key_rdy, o_keys_vld, o_done);
      end
      read_slot(4'd0,  FIPS_KEY, "fips_slot0");
      read_slot(4'd1,  FIPS_K1,  "fips_slot1");
      read_slot(4'd10, FIPS_K10, "fips_slot10");
      for (int i = 2; i < NR; i++) read_slot(4'(i), exp_keys[i], "fips_slot_mid");
   endtask

   task automatic test_back_to_back();
      logic [3:0] idx_list [0:12];
      logic [127:0] held;
      for (int i = 0; i <= NR; i++) idx_list[i + 2] = 4'(i);
      idx_list[0] = 4'd11; idx_list[1] = 4'd15;
      i_rd_en = 1'b1; i_rd_idx = idx_list[0];
      for (int k = 0; k < 13; k++) begin
         @(posedge clk); #1;
         if (k < 12) i_rd_idx = idx_list[k + 1];
         else i_rd_en = 1'b0;
         checks++;
         if (o_rd_vld !== 1'b1 || o_rd_key !== exp_keys[idx_list[k]]) begin
            failures++;
            $display("FAIL b2b_read idx=%0d: vld=%0b key=%h required 1 %h",
                     idx_list[k], o_rd_vld, o_rd_key, exp_keys[idx_list[k]]);
         end
      end
      held = FIPS_K10;
      @(posedge clk); #1;
      checks++;
      if (o_rd_vld !== 1'b0 || o_rd_key !== held) begin
         failures++;
         $display("FAIL b2b_hold: vld=%0b key=%h required 0 %h", o_rd_vld, o_rd_key, held);
      end
   endtask

   task automatic test_zero_key();
      send_key(128'h0);
      wait_done();
      checks++;
      if (o_keys_vld !== 1'b1) begin
         failures++;
         $display("FAIL zero_keys_vld: got %0b required 1", o_keys_vld);
      end
      read_slot(4'd1,  ZERO_K1,  "zero_slot1");
      read_slot(4'd10, ZERO_K10, "zero_slot10");
   endtask

   task automatic test_hold_during_expand();
      int miss;
      send_key(OTHER_KEY);
      // second key offered continuously while the first one expands
      i_key = FIPS_KEY; i_key_vld = 1'b1;
      miss = 0;
      for (int c = 1; c <= NR; c++) begin
         checks++;
         if (o_key_rdy !== 1'b0 || o_busy !== 1'b1) begin
            failures++; miss++;
            $display("FAIL hold_not_accepted cyc=%0d: rdy=%0b busy=%0b required 0 1", c, o_key_rdy, o_busy);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (o_done !== 1'b1) begin
         failures++;
         $display("FAIL hold_first_done: got %0b required 1", o_done);
      end
      @(posedge clk); #1;
      checks++;
      if (o_key_rdy !== 1'b1 || o_keys_vld !== 1'b1) begin
         failures++;
         $display("FAIL hold_ready_again: rdy=%0b kv=%0b required 1 1", o_key_rdy, o_keys_vld);
      end
      @(posedge clk); #1;
      i_key_vld = 1'b0;
      checks++;
      if (o_keys_vld !== 1'b0 || o_busy !== 1'b1 || o_kg_pre_key !== FIPS_KEY) begin
         failures++;
         $display("FAIL hold_second_accept: kv=%0b busy=%0b pre=%h required 0 1 %h",
                  o_keys_vld, o_busy, o_kg_pre_key, FIPS_KEY);
      end
      wait_done();
      read_slot(4'd0,  FIPS_KEY, "hold_slot0");
      read_slot(4'd10, FIPS_K10, "hold_slot10");
   endtask

   task automatic test_reset_mid();
      int n;
      send_key(FIPS_KEY);
      n = 0;
      while (o_kg_round !== 4'd5 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (o_kg_round !== 4'd5) begin
         failures++;
         $display("FAIL rstmid_reach_rnd5: got %0d required 5", o_kg_round);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({o_busy, o_done, o_keys_vld, o_rd_vld, o_kg_en} !== 5'b0 ||
          o_kg_round !== 4'd0 || o_kg_pre_key !== '0 || o_rd_key !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs: busy=%0b done=%0b kv=%0b rv=%0b en=%0b rnd=%0d pre=%h rd=%h required all 0",
                  o_busy, o_done, o_keys_vld, o_rd_vld, o_kg_en, o_kg_round, o_kg_pre_key, o_rd_key);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o_key_rdy !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_key_rdy: got %0b required 1", o_key_rdy);
      end
      read_slot(4'd0, 128'h0, "rstmid_slot0");
      read_slot(4'd3, 128'h0, "rstmid_slot3");
      send_key(128'h0);
      wait_done();
      read_slot(4'd10, ZERO_K10, "rstmid_fresh_slot10");
   endtask

`ifdef AES_KEYSCHED_ZEROIZE_EN
   task automatic test_zeroize();
      int n;
      bit saw_done;
      send_key(FIPS_KEY);
      n = 0;
      while (o_kg_round !== 4'd3 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      i_zeroize = 1'b1;
      i_rd_en = 1'b1; i_rd_idx = 4'd0;
      @(posedge clk); #1;
      i_zeroize = 1'b0; i_rd_en = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_keys_vld !== 1'b0 ||
          o_key_rdy !== 1'b1 || o_rd_key !== '0) begin
         failures++;
         $display("FAIL zeroize_outputs: busy=%0b done=%0b kv=%0b rdy=%0b rd=%h required 0 0 0 1 0",
                  o_busy, o_done, o_keys_vld, o_key_rdy, o_rd_key);
      end
      saw_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (o_done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL zeroize_no_done: o_done seen=1 required 0");
      end
      read_slot(4'd0, 128'h0, "zeroize_slot0");
      read_slot(4'd1, 128'h0, "zeroize_slot1");
   endtask
`endif

   initial begin
      rst = 1'b1; i_key_vld = 1'b0; i_key = '0;
      i_rd_en = 1'b0; i_rd_idx = 4'd0; i_zeroize = 1'b0;
      test_reset();
      test_fips();
      test_back_to_back();
      test_zero_key();
      test_hold_during_expand();
      test_reset_mid();
`ifdef AES_KEYSCHED_ZEROIZE_EN
      test_zeroize();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
